// File: rtl/apb_slave_mem.sv
// apb_slave_mem -- parametrised APB slave memory.
//
// Word-addressed memory on an APB bus with a two-state access FSM. It
// supports programmable wait states, byte-lane write strobes, an error
// response for out-of-range addresses, and a registered read path.
//
// Parameters:
//   DATA_WIDTH   data bus width, multiple of 8 (8..32)
//   ADDR_WIDTH   PADDR width (word address)
//   DEPTH        number of words, 1 <= DEPTH <= 2**ADDR_WIDTH
//   WAIT_STATES  extra access-phase cycles before PREADY (0..15)
//
// Ports:
//   PCLK     in   bus clock, rising edge
//   PRESET   in   asynchronous active-high reset
//   PSEL     in   slave select
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   word address
//   PWDATA   in   write data
//   PSTRB    in   byte-lane write enables
//   PRDATA   out  registered read data
//   PREADY   out  transfer completes this cycle
//   PSLVERR  out  error response, valid with PREADY
module apb_slave_mem #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]            state_reg;
  logic [3:0]            cnt_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [IDX_W-1:0]      idx;
  logic                  addr_ok;
  logic                  setup;
  logic                  cnt_zero;
  logic                  mem_we;

  // Only the low index bits address the array; out-of-range addresses are
  // filtered by addr_ok before any array access has an effect.
  assign idx      = PADDR[IDX_W-1:0];
  assign addr_ok  = (32'(PADDR) < 32'(DEPTH));
  assign setup    = (state_reg == ST_IDLE) && PSEL && !PENABLE;
  assign cnt_zero = (cnt_reg == 4'd0);

  assign PREADY  = (state_reg == ST_ACCESS) && PSEL && PENABLE && cnt_zero;
  assign PSLVERR = PREADY && err_reg;

  // Write address and data are taken at the completing edge; the range check
  // there uses the live address, which the master holds stable.
  assign mem_we = PREADY && PWRITE && addr_ok;

  // One byte-wide RAM per lane so each strobe maps onto its own write enable.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge PCLK) begin
        if (mem_we && PSTRB[gi]) begin
          mem[idx] <= PWDATA[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = mem[idx];
    end
  endgenerate

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      err_reg   <= 1'b0;
      PRDATA    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // PENABLE without a preceding setup phase is not a transfer.
          if (setup) begin
            state_reg <= ST_ACCESS;
            cnt_reg   <= 4'(WAIT_STATES);
            err_reg   <= !addr_ok;
            // Read data is captured once, at setup, and held for the whole
            // access phase; writes and errored reads present zero.
            PRDATA    <= (!PWRITE && addr_ok) ? rd_word : '0;
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            state_reg <= ST_IDLE;          // master abandoned the transfer
          end else if (PENABLE && !cnt_zero) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else if (PREADY) begin
            state_reg <= ST_IDLE;          // allows back-to-back setup next cycle
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

Parametrised APB slave memory: the next-generation replacement for the fixed 8-bit single-bank APB slave on the two-slave bus. It adds configurable data/address width and depth, programmable wait states, byte write strobes, an out-of-range error response, and a registered read path with an explicit access state machine. It sits behind the APB decoder, one instance per slave select.

## Interface
- DATA_WIDTH, 8, data bus width; multiple of 8, range 8..32
- ADDR_WIDTH, 8, PADDR width; word addressing, so PADDR indexes words directly
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
- WAIT_STATES, 0, extra access-phase cycles before PREADY; range 0..15
- PCLK  in  1  bus clock; all state changes on the rising edge
- PRESET  in  1  asynchronous, active-high reset
- PSEL  in  1  slave select
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  word address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  byte-lane write enables; bit i covers PWDATA[8i+7:8i]
- PRDATA  out  DATA_WIDTH  read data, registered
- PREADY  out  1  transfer completes on this cycle
- PSLVERR  out  1  error response; meaningful only while PREADY=1

## Operation
- FSM has two states. IDLE: no transfer in progress. ACCESS: access phase, wait counter running.
- In IDLE, on an edge with PSEL=1 and PENABLE=0 (setup phase):
  - go to ACCESS
  - load wait counter with WAIT_STATES
  - latch err = (PADDR >= DEPTH)
  - load PRDATA with mem[PADDR] for an in-range read, otherwise with 0
- In ACCESS:
  - PREADY = (PSEL & PENABLE & counter==0), decoded from registered state.
  - On an edge with PSEL=1, PENABLE=1 and counter!=0, decrement the counter.
  - On an edge with PREADY=1, return to IDLE, so back-to-back transfers are allowed. For a write that is in range, write each lane i of mem[PADDR] whose PSTRB[i]=1.
- PSLVERR = PREADY & err. An errored write leaves the memory unchanged. An errored read returns PRDATA=0.
- A write with PSTRB all 0 completes normally and changes no memory.
- PSEL deasserted while in ACCESS: abort to IDLE with no write and PREADY=0.
- PENABLE=1 while in IDLE (no setup phase seen): ignored, PREADY stays 0, no memory effect.
- PADDR, PWRITE, PWDATA and PSTRB are sampled at the completing edge for the write. The master holds them stable per APB; the slave does not check this.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (asynchronous, effective immediately):
  - FSM goes to IDLE and the counter to 0.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - Reset asserted mid-wait aborts the transfer with no write. After release the slave waits for a fresh setup phase.
- WAIT_STATES=0: PREADY=1 in the first access cycle, so each transfer takes 2 cycles (setup plus access).
- WAIT_STATES=N: PREADY=0 for N access cycles, then 1 on access cycle N+1, so each transfer takes N+2 cycles.
- Write latency: memory is updated at the edge that ends the PREADY=1 cycle. A read issued in the next setup phase returns the new data.
- PRDATA is stable from the cycle after setup through the end of the access phase.
- Outside ACCESS: PREADY=0 and PSLVERR=0. PRDATA holds its last value.

## Test plan
- Reset, then write 0xA5 to address 3 with PSTRB=1 and WAIT_STATES=0, then read address 3. Required: each transfer takes 2 cycles, PREADY=1 on the access cycle, PRDATA=0xA5, PSLVERR=0.
- DATA_WIDTH=32: write 0x11223344 to address 5 with PSTRB=1111, then 0xAABBCCDD with PSTRB=0101, then read address 5. Required: read returns 0x11BB33DD.
- WAIT_STATES=3: one read. Required: PREADY=0 for 3 access cycles and 1 on the 4th; transfer takes 5 cycles; PRDATA is held throughout the access phase.
- DEPTH=200, ADDR_WIDTH=8: write then read address 250. Required: PSLVERR=1 with PREADY=1 on both transfers, PRDATA=0, and a read of address 250 mod 200 = 50 shows no change.
- WAIT_STATES=4: assert PRESET during the 2nd wait cycle of a write to address 7 (previously 0x3C). Required: PREADY/PSLVERR/PRDATA go to 0 immediately; a later read of address 7 returns 0x3C.
- Abort with WAIT_STATES=2: drop PSEL mid-access on a write. Required: no write occurs. Also drive back-to-back transfers with no idle cycle between them: both complete correctly.
